// File: rtl/wah_tdm_biquad.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wah_tdm_biquad                                                  |
// | Brief    : Time-multiplexed multi-channel biquad with banked coefficients  |
// |            and per-frame dry/wet mix, one shared MAC.                      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module wah_tdm_biquad #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int NUM_CHANNELS = 2,
    parameter int COEFF_WIDTH  = 24,
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                                 system_clock,
    input  logic                                 rst,
    input  logic                                 sample_strobe,
    input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] sample_in,
    input  logic [3:0]                           wet_mix,
    input  logic                                 coeff_valid,
    output logic                                 coeff_ready,
    input  logic [CH_W-1:0]                      coeff_ch,
    input  logic [2:0]                           coeff_sel,
    input  logic [COEFF_WIDTH-1:0]               coeff_data,
    input  logic                                 coeff_commit,
    output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] sample_out,
    output logic                                 out_valid,
    output logic                                 busy,
    output logic                                 overrun
);

    localparam int c_AW   = SAMPLE_WIDTH + COEFF_WIDTH + 3;
    localparam int c_F    = COEFF_WIDTH - 2;
    localparam int c_MW   = SAMPLE_WIDTH + 4;
    localparam int c_NC   = NUM_CHANNELS * 5;
    localparam int c_CI_W = $clog2(c_NC);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    localparam logic signed [COEFF_WIDTH-1:0]  c_ONE  = COEFF_WIDTH'(1) << c_F;
    localparam logic signed [c_AW-1:0]         c_HALF = c_AW'(1) << (c_F - 1);
    localparam logic signed [SAMPLE_WIDTH-1:0] c_SMAX = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic signed [SAMPLE_WIDTH-1:0] c_SMIN = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
    localparam logic signed [c_AW-1:0]         c_YMAX = c_AW'(c_SMAX);
    localparam logic signed [c_AW-1:0]         c_YMIN = c_AW'(c_SMIN);

    logic [0:0]                     r_state;
    logic [CH_W-1:0]                r_ch;
    logic [2:0]                     r_step;
    logic [3:0]                     r_wet;
    logic                           r_pend;
    logic                           r_ovr;
    logic                           r_valid;
    logic signed [c_AW-1:0]         r_acc;
    logic signed [SAMPLE_WIDTH-1:0] r_x   [NUM_CHANNELS];
    logic signed [SAMPLE_WIDTH-1:0] r_x1  [NUM_CHANNELS];
    logic signed [SAMPLE_WIDTH-1:0] r_x2  [NUM_CHANNELS];
    logic signed [SAMPLE_WIDTH-1:0] r_y1  [NUM_CHANNELS];
    logic signed [SAMPLE_WIDTH-1:0] r_y2  [NUM_CHANNELS];
    logic signed [SAMPLE_WIDTH-1:0] r_mix [NUM_CHANNELS];
    logic signed [SAMPLE_WIDTH-1:0] r_out [NUM_CHANNELS];
    logic signed [COEFF_WIDTH-1:0]  r_sh  [c_NC];
    logic signed [COEFF_WIDTH-1:0]  r_act [c_NC];

    logic [2:0]                     w_tap;
    logic [c_CI_W-1:0]              w_cidx;
    logic [c_CI_W-1:0]              w_widx;
    logic                           w_wr;
    logic signed [COEFF_WIDTH-1:0]  w_coef;
    logic signed [SAMPLE_WIDTH-1:0] w_opnd;
    logic signed [SAMPLE_WIDTH-1:0] w_x;
    logic signed [SAMPLE_WIDTH-1:0] w_y;
    logic signed [SAMPLE_WIDTH-1:0] w_mix;
    logic signed [c_AW-1:0]         w_prod;
    logic signed [c_AW-1:0]         w_rnd;
    logic signed [c_AW-1:0]         w_shift;
    logic [4:0]                     w_weff;
    logic signed [c_MW-1:0]         w_mix_sum;
    logic                           w_unused_mix_lsbs;

    // Tap index 0..4 = b0,b1,b2,a1,a2; the writeback step reuses tap 0 harmlessly.
    assign w_tap  = (r_step < 3'd5) ? r_step : 3'd0;
    assign w_cidx = c_CI_W'(r_ch) * c_CI_W'(5) + c_CI_W'(w_tap);
    assign w_coef = r_act[w_cidx];
    assign w_x    = r_x[r_ch];

    always_comb begin
        w_opnd = r_x[r_ch];
        case (w_tap)
            3'd1:    w_opnd = r_x1[r_ch];
            3'd2:    w_opnd = r_x2[r_ch];
            3'd3:    w_opnd = r_y1[r_ch];
            3'd4:    w_opnd = r_y2[r_ch];
            default: w_opnd = r_x[r_ch];
        endcase
    end

    assign w_prod  = c_AW'(w_coef) * c_AW'(w_opnd);
    assign w_rnd   = r_acc + c_HALF;
    assign w_shift = w_rnd >>> c_F;

    always_comb begin
        if (w_shift > c_YMAX) begin
            w_y = c_SMAX;
        end else if (w_shift < c_YMIN) begin
            w_y = c_SMIN;
        end else begin
            w_y = w_shift[SAMPLE_WIDTH-1:0];
        end
    end

    // Full wet is 16/16 so that the top code reproduces y exactly.
    assign w_weff    = (r_wet == 4'hF) ? 5'd16 : {1'b0, r_wet};
    assign w_mix_sum = c_MW'(w_x) * $signed(c_MW'(5'd16 - w_weff))
                     + c_MW'(w_y) * $signed(c_MW'(w_weff));
    assign w_mix             = w_mix_sum[SAMPLE_WIDTH+3:4];
    assign w_unused_mix_lsbs = ^w_mix_sum[3:0];

    assign coeff_ready = !r_pend && !rst;
    assign w_wr   = coeff_valid && coeff_ready
                 && ({1'b0, coeff_ch} < (CH_W+1)'(NUM_CHANNELS))
                 && (coeff_sel < 3'd5);
    assign w_widx = c_CI_W'(coeff_ch) * c_CI_W'(5) + c_CI_W'(coeff_sel);

    always_ff @(posedge system_clock) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_ch    <= '0;
            r_step  <= '0;
            r_wet   <= '0;
            r_pend  <= 1'b0;
            r_ovr   <= 1'b0;
            r_valid <= 1'b0;
            r_acc   <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_x[i]   <= '0;
                r_x1[i]  <= '0;
                r_x2[i]  <= '0;
                r_y1[i]  <= '0;
                r_y2[i]  <= '0;
                r_mix[i] <= '0;
                r_out[i] <= '0;
            end
            for (int i = 0; i < c_NC; i++) begin
                r_sh[i]  <= (i % 5 == 0) ? c_ONE : '0;
                r_act[i] <= (i % 5 == 0) ? c_ONE : '0;
            end
        end else begin
            r_valid <= 1'b0;
            if (w_wr) begin
                r_sh[w_widx] <= coeff_data;
            end
            case (r_state)
                c_IDLE: begin
                    if (sample_strobe) begin
                        for (int i = 0; i < NUM_CHANNELS; i++) begin
                            r_x[i] <= sample_in[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                        end
                        r_wet <= wet_mix;
                        if (r_pend) begin
                            r_act  <= r_sh;
                            r_pend <= 1'b0;
                        end
                        r_ch    <= '0;
                        r_step  <= '0;
                        r_state <= c_RUN;
                    end
                end
                default: begin
                    if (sample_strobe) begin
                        r_ovr <= 1'b1;
                    end
                    case (r_step)
                        3'd0:       r_acc <= w_prod;
                        3'd1, 3'd2: r_acc <= r_acc + w_prod;
                        3'd3, 3'd4: r_acc <= r_acc - w_prod;
                        default:    r_acc <= r_acc;
                    endcase
                    if (r_step == 3'd5) begin
                        r_x2[r_ch]  <= r_x1[r_ch];
                        r_x1[r_ch]  <= w_x;
                        r_y2[r_ch]  <= r_y1[r_ch];
                        r_y1[r_ch]  <= w_y;
                        r_mix[r_ch] <= w_mix;
                        r_step      <= '0;
                        if (r_ch == CH_W'(NUM_CHANNELS - 1)) begin
                            // All channels publish together; the last one bypasses r_mix.
                            for (int i = 0; i < NUM_CHANNELS - 1; i++) begin
                                r_out[i] <= r_mix[i];
                            end
                            r_out[NUM_CHANNELS-1] <= w_mix;
                            r_valid <= 1'b1;
                            r_state <= c_IDLE;
                        end else begin
                            r_ch <= r_ch + CH_W'(1);
                        end
                    end else begin
                        r_step <= r_step + 3'd1;
                    end
                end
            endcase
            if (coeff_commit) begin
                r_pend <= 1'b1;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_out
            assign sample_out[g*SAMPLE_WIDTH +: SAMPLE_WIDTH] = r_out[g];
        end
    endgenerate

    assign out_valid = r_valid;
    assign busy      = (r_state == c_RUN);
    assign overrun   = r_ovr;

endmodule
`default_nettype wire
